ahfp_i2f: RTL and testbench

//  Pipelined integer-to-IEEE-754 single-precision converter. Upstream stage of the

---
 rtl/ahfp_i2f.sv | 115 +++++++++++
 tb/tb_ahfp_i2f.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ahfp_i2f.sv
// Pipelined 32-bit integer to IEEE-754 single-precision converter (start/done interface).
// Latency: start sampled at enabled edge N gives done/result after enabled edge N+3; fully pipelined.
// Backpressure: none; clk_en=0 freezes every register, done is a pulse and is never acknowledged.
//
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous active-high reset; discards work in flight
//   clk_en  pipeline enable; low holds every register
//   start   operand valid, sampled when clk_en=1
//   dataa   integer operand (signed or unsigned per SIGNED)
//   done    one-cycle result-valid pulse per start
//   result  IEEE-754 single, holds its value between dones
module ahfp_i2f #(
   parameter logic SIGNED     = 1'b1,  // 1: dataa is two's complement
   parameter logic ROUND_MODE = 1'b0   // 0: round-to-nearest-even, 1: truncate
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_en,
   input  logic        start,
   input  logic [31:0] dataa,
   output logic        done,
   output logic [31:0] result
);

   // Stage 1: sign and magnitude
   logic        v1;
   logic        sign1;
   logic [31:0] mag1;

   // Stage 2: normalised magnitude; norm2[31]=0 only for a zero operand
   logic        v2;
   logic        sign2;
   logic [4:0]  lzc2;
   logic [31:0] norm2;

   // Stage 3: rounded and packed float
   logic        v3;
   logic [31:0] res3;

   // Stage 1 combinational
   logic        sign_d;
   logic [31:0] mag_d;

   always_comb begin
      sign_d = SIGNED & dataa[31];
      // 0x80000000 negates to itself, which is the correct unsigned magnitude
      mag_d  = sign_d ? (~dataa + 32'd1) : dataa;
   end

   // Stage 2 combinational: leading-zero count; the highest set bit wins
   logic [4:0] lzc_d;

   always_comb begin
      lzc_d = 5'd0;
      for (int i = 0; i < 32; i++) begin
         if (mag1[i]) lzc_d = 5'(31 - i);
      end
   end

   // Stage 3 combinational: round and pack
   logic [22:0] frac;
   logic        guard;
   logic        sticky;
   logic        inc;
   logic [23:0] frac_sum;
   logic [7:0]  exp_base;
   logic [7:0]  exp_rnd;
   logic [31:0] packed_d;

   always_comb begin
      frac     = norm2[30:8];
      guard    = norm2[7];
      sticky   = |norm2[6:0];
      inc      = ROUND_MODE ? 1'b0 : (guard & (sticky | frac[0]));
      frac_sum = {1'b0, frac} + {23'd0, inc};
      exp_base = 8'd158 - {3'd0, lzc2};
      // A carry out of the fraction leaves frac_sum[22:0]=0 and bumps the exponent
      exp_rnd  = frac_sum[23] ? (exp_base + 8'd1) : exp_base;
      if (!norm2[31]) packed_d = 32'h0000_0000;  // zero input: always +0
      else            packed_d = {sign2, exp_rnd, frac_sum[22:0]};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v1     <= 1'b0;
         sign1  <= 1'b0;
         mag1   <= 32'd0;
         v2     <= 1'b0;
         sign2  <= 1'b0;
         lzc2   <= 5'd0;
         norm2  <= 32'd0;
         v3     <= 1'b0;
         res3   <= 32'd0;
         done   <= 1'b0;
         result <= 32'd0;
      end else if (clk_en) begin
         v1    <= start;
         sign1 <= sign_d;
         mag1  <= mag_d;

         v2    <= v1;
         sign2 <= sign1;
         lzc2  <= lzc_d;
         norm2 <= mag1 << lzc_d;

         v3    <= v2;
         res3  <= packed_d;

         done  <= v3;
         if (v3) result <= res3;
      end
   end

endmodule

// File: tb/tb_ahfp_i2f.sv
// Bench for ahfp_i2f: three instances (signed RNE, signed truncate, unsigned RNE)
// share dataa and each has its own start; a scoreboard records the expected value
// and the enabled-edge count at which done must appear.
module tb_ahfp_i2f;

   logic        clk = 1'b0;
   logic        reset;
   logic        clk_en;
   logic [31:0] dataa;
   logic [2:0]  start;
   logic [2:0]  done;
   logic [31:0] res0, res1, res2;

   always #5 clk = ~clk;

   ahfp_i2f #(.SIGNED(1'b1), .ROUND_MODE(1'b0)) u_srne (
      .clk(clk), .reset(reset), .clk_en(clk_en), .start(start[0]),
      .dataa(dataa), .done(done[0]), .result(res0));
   ahfp_i2f #(.SIGNED(1'b1), .ROUND_MODE(1'b1)) u_strn (
      .clk(clk), .reset(reset), .clk_en(clk_en), .start(start[1]),
      .dataa(dataa), .done(done[1]), .result(res1));
   ahfp_i2f #(.SIGNED(1'b0), .ROUND_MODE(1'b0)) u_urne (
      .clk(clk), .reset(reset), .clk_en(clk_en), .start(start[2]),
      .dataa(dataa), .done(done[2]), .result(res2));

   typedef struct {
      int          dut;
      logic [31:0] val;
      int          due;
   } exp_t;

   typedef struct {
      int          dut;
      logic [31:0] a;
      logic [31:0] e;
      int          gap;
   } vec_t;

   exp_t        sb[$];
   vec_t        tbl[$];
   int          compared   = 0;
   int          mismatched = 0;
   int          en_cyc     = 0;
   logic [31:0] last_res0  = 32'd0;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Count enabled edges; latency is measured in these
   always @(posedge clk) begin
      if (clk_en && !reset) en_cyc <= en_cyc + 1;
   end

   // Scoreboard monitor: a done is consumed only on a cycle whose next edge is enabled
   always @(negedge clk) begin
      if (!reset && clk_en) begin
         for (int k = 0; k < 3; k++) begin
            if (done[k]) begin
               int          idx;
               logic [31:0] r;
               idx = -1;
               for (int j = 0; j < sb.size(); j++) begin
                  if (idx < 0 && sb[j].dut == k) idx = j;
               end
               r = (k == 0) ? res0 : (k == 1) ? res1 : res2;
               if (idx < 0) begin
                  compared++;
                  mismatched++;
                  $display("FAIL unexpected_done dut%0d: got done=1 result=%h, expected no done", k, r);
               end else begin
                  cmp($sformatf("result dut%0d", k), r, sb[idx].val);
                  cmp($sformatf("latency dut%0d", k), 32'(en_cyc), 32'(sb[idx].due));
                  if (k == 0) last_res0 = sb[idx].val;
                  sb.delete(idx);
               end
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive one start just after an edge; it is sampled at the next edge and
   // must complete three enabled edges later.
   task automatic drive(input int k, input logic [31:0] a, input logic [31:0] e);
      exp_t x;
      dataa    = a;
      start    = 3'b000;
      start[k] = 1'b1;
      x.dut = k;
      x.val = e;
      x.due = en_cyc + 4;
      sb.push_back(x);
      @(posedge clk);
      #1;
      start = 3'b000;
   endtask

   initial begin
      reset  = 1'b1;
      clk_en = 1'b1;
      start  = 3'b000;
      dataa  = 32'd0;

      // dut, operand, expected, idle cycles afterwards
      tbl.push_back('{0, 32'h0000_0001, 32'h3F80_0000, 4});
      tbl.push_back('{0, 32'h0000_0002, 32'h4000_0000, 4});
      tbl.push_back('{0, 32'h0000_0000, 32'h0000_0000, 4});
      tbl.push_back('{0, 32'hFFFF_FFFF, 32'hBF80_0000, 4});
      tbl.push_back('{0, 32'd1000,      32'h447A_0000, 0});
      tbl.push_back('{0, 32'hFFFF_FE0C, 32'hC3FA_0000, 0});
      tbl.push_back('{0, 32'd3,         32'h4040_0000, 4});
      tbl.push_back('{0, 32'h0100_0001, 32'h4B80_0000, 0});
      tbl.push_back('{0, 32'h0100_0003, 32'h4B80_0002, 0});
      tbl.push_back('{0, 32'h7FFF_FFFF, 32'h4F00_0000, 0});
      tbl.push_back('{1, 32'h7FFF_FFFF, 32'h4EFF_FFFF, 0});
      tbl.push_back('{1, 32'h0100_0003, 32'h4B80_0001, 0});
      tbl.push_back('{1, 32'hFFFF_FFFF, 32'hBF80_0000, 0});
      tbl.push_back('{0, 32'h8000_0000, 32'hCF00_0000, 0});
      tbl.push_back('{2, 32'h8000_0000, 32'h4F00_0000, 0});
      tbl.push_back('{2, 32'hFFFF_FFFF, 32'h4F80_0000, 0});
      tbl.push_back('{2, 32'h0000_0000, 32'h0000_0000, 0});
      tbl.push_back('{2, 32'h0100_0001, 32'h4B80_0000, 0});
      tbl.push_back('{0, 32'h00FF_FFFF, 32'h4B7F_FFFF, 6});

      // Reset state
      @(posedge clk);
      #1;
      cmp("reset done", {29'd0, done}, 32'd0);
      cmp("reset res0", res0, 32'd0);
      cmp("reset res1", res1, 32'd0);
      cmp("reset res2", res2, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Table-driven vectors, including back-to-back starts
      foreach (tbl[i]) begin
         drive(tbl[i].dut, tbl[i].a, tbl[i].e);
         idle(tbl[i].gap);
      end

      // clk_en freeze mid-flight
      drive(0, 32'd7, 32'h40E0_0000);
      idle(1);
      clk_en = 1'b0;
      repeat (5) begin
         @(negedge clk);
         cmp("freeze done", {31'd0, done[0]}, 32'd0);
         cmp("freeze result", res0, last_res0);
         @(posedge clk);
         #1;
      end
      clk_en = 1'b1;
      idle(5);

      // Reset mid-flight discards the work
      drive(0, 32'd5, 32'h40A0_0000);
      reset = 1'b1;
      sb.delete();
      #1;
      cmp("midreset done", {29'd0, done}, 32'd0);
      cmp("midreset res0", res0, 32'd0);
      idle(2);
      @(negedge clk);
      reset = 1'b0;
      last_res0 = 32'd0;
      idle(6);
      cmp("post-reset res0", res0, 32'd0);
      drive(0, 32'd1, 32'h3F80_0000);
      idle(5);

      // Drain with a bound
      begin
         int t;
         t = 0;
         while (sb.size() != 0 && t < 50) begin
            @(posedge clk);
            t++;
         end
      end
      while (sb.size() != 0) begin
         compared++;
         mismatched++;
         $display("FAIL missing_done dut%0d: got no done, expected %h", sb[0].dut, sb[0].val);
         sb.delete(0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
